// File: rtl/fpmul_regs_pkg.sv
// Register map constants and driver state encoding shared by the
// FP-multiplier register block, its bus driver and software headers.
package fpmul_regs_pkg;

  localparam logic [1:0] ADDR_OPA      = 2'b00;
  localparam logic [1:0] ADDR_OPB      = 2'b01;
  localparam logic [1:0] ADDR_CTRL_RES = 2'b10;
  localparam logic [1:0] ADDR_STAT     = 2'b11;

  localparam int START_BIT = 16;
  localparam int DONE_BIT  = 0;
  localparam int FLAG_LSB  = 8;
  localparam int FLAG_W    = 6;

  localparam logic [31:0] START_WORD = 32'h1 << START_BIT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_GO,
    ST_SETTLE,
    ST_POLL,
    ST_RD_RES,
    ST_RESP
  } drv_state_e;

endpackage

// File: rtl/fpmul_bus_driver.sv
// Bus initiator for the FP-multiplier register block: takes an operand pair,
// writes OpA/OpB/start, polls status for done, reads the product and returns
// it with the exception flags on a valid/ready response port.
// Optional poll timeout: define FPMUL_DRV_TIMEOUT_EN.
module fpmul_bus_driver
  import fpmul_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_a,
  input  logic [31:0]       cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_p,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_timeout,
  output logic [1:0]        A,
  output logic              WE,
  output logic [31:0]       WData,
  input  logic [31:0]       RData,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  drv_state_e        state_q, state_d;
  logic [31:0]       a_q, b_q, p_q;
  logic [FLAG_W-1:0] flags_q;
  logic              done_seen;
  logic              timeout_fire;

  assign done_seen = RData[DONE_BIT];

`ifdef FPMUL_DRV_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] poll_cnt_q;
  logic             timeout_q;

  // Abort on the last permitted POLL cycle that still shows no done.
  assign timeout_fire = (state_q == ST_POLL) && !done_seen &&
                        (poll_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Poll-cycle counter and the sticky abort indication for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == ST_SETTLE) begin
        poll_cnt_q <= '0;
      end else if (state_q == ST_POLL && !done_seen) begin
        poll_cnt_q <= poll_cnt_q + 1'b1;
      end
      if (state_q == ST_IDLE && cmd_valid) begin
        timeout_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  // State register plus operand, product and flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register in a clocked process uses <= so all of them
      // update from the same pre-edge values, whatever the statement order.
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_q <= cmd_a;
            b_q <= cmd_b;
          end
        end
        ST_POLL: begin
          if (done_seen) begin
            flags_q <= RData[FLAG_LSB +: FLAG_W];
          end else if (timeout_fire) begin
            p_q     <= '0;
            flags_q <= '0;
          end
        end
        ST_RD_RES: p_q <= RData;
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore bus/handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    A       = ADDR_OPA;
    WE      = 1'b0;
    WData   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = ST_WR_A;
      end
      ST_WR_A: begin
        A       = ADDR_OPA;
        WE      = 1'b1;
        WData   = a_q;
        state_d = ST_WR_B;
      end
      ST_WR_B: begin
        A       = ADDR_OPB;
        WE      = 1'b1;
        WData   = b_q;
        state_d = ST_WR_GO;
      end
      ST_WR_GO: begin
        A       = ADDR_CTRL_RES;
        WE      = 1'b1;
        WData   = START_WORD;
        state_d = ST_SETTLE;
      end
      // One idle status read so a Done left over from the previous
      // operation has been cleared by the start write before polling.
      ST_SETTLE: begin
        A       = ADDR_STAT;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        A = ADDR_STAT;
        if (done_seen)         state_d = ST_RD_RES;
        else if (timeout_fire) state_d = ST_RESP;
      end
      ST_RD_RES: begin
        A       = ADDR_CTRL_RES;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_p     = p_q;
  assign rsp_flags = flags_q;

endmodule

// File: tb/tb_fpmul_bus_driver.sv
// Self-checking bench for fpmul_bus_driver: a behavioural register-block
// model answers the bus, and each transaction is scored against the
// expected write sequence, product, flags and response latency.
module tb_fpmul_bus_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_p;
  logic [5:0]  rsp_flags;
  logic        rsp_timeout;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpmul_bus_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .A(A), .WE(WE), .WData(WData), .RData(RData), .busy(busy)
  );

  // ---------------- register-block model ----------------
  // Configuration for the next operation, set by the stimulus.
  logic [31:0] nx_prod;
  logic [5:0]  nx_flags;
  int          nx_delay;   // done visible this many cycles after the start write cycle
  bit          nx_never;   // never raise done

  logic [31:0] m_prod  = 32'h0;
  logic [5:0]  m_flags = 6'h0;
  logic        m_done  = 1'b0;
  logic        m_start = 1'b0;
  bit          m_run   = 1'b0;
  int          m_pend  = 0;

  logic [33:0] wr_q[$];

  always @(posedge clk) begin
    if (WE) begin
      wr_q.push_back({A, WData});
      if (A == 2'b10) begin
        m_start <= WData[16];
        if (WData[16]) begin
          m_done <= 1'b0;
          m_run  <= !nx_never;
          m_pend <= nx_delay - 1;
        end
      end
    end else if (m_run) begin
      if (m_pend == 0) begin
        m_done  <= 1'b1;
        m_prod  <= nx_prod;
        m_flags <= nx_flags;
        m_run   <= 1'b0;
      end else begin
        m_pend <= m_pend - 1;
      end
    end
  end

  always_comb begin
    RData = 32'h0;
    if (A == 2'b10)      RData = m_prod;
    else if (A == 2'b11) RData = {15'h0, m_start, 2'b00, m_flags, 7'h0, m_done};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a command at the current negedge and wait for it to be taken.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Cycles from the accept cycle (index 0) to the first rsp_valid cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  // Full transaction with model setup, scoring and optional backpressure.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input logic [5:0] flags,
                         input int delay, input int bp);
    int lat, exp_lat;
    nx_prod = prod; nx_flags = flags; nx_delay = delay; nx_never = 0;
    wr_q.delete();
    issue(a, b);
    wait_rsp(lat);
    // WR_GO is cycle 3, first POLL cycle 5; response two cycles after done is seen.
    exp_lat = ((4 + delay) > 5 ? (4 + delay) : 5) + 2;
    check("latency", lat, exp_lat);
    check("rsp_p", rsp_p, prod);
    check("rsp_flags", {26'h0, rsp_flags}, {26'h0, flags});
    check("rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    rsp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_p", rsp_p, prod);
      check("bp_flags", {26'h0, rsp_flags}, {26'h0, flags});
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", {31'h0, rsp_valid}, 32'h0);
    check("post_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("wr_count", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      check("wr_opa", wr_q[0], {2'b00, a});
      check("wr_opb", wr_q[1], {2'b01, b});
      check("wr_go",  wr_q[2], {2'b10, 32'h0001_0000});
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    nx_prod = '0; nx_flags = '0; nx_delay = 1; nx_never = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_p", rsp_p, 32'h0);
    check("rst_flags", {26'h0, rsp_flags}, 32'h0);
    check("rst_timeout", {31'h0, rsp_timeout}, 32'h0);
    check("rst_A", {30'h0, A}, 32'h0);
    check("rst_WE", {31'h0, WE}, 32'h0);
    check("rst_WData", WData, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 * 2.0, done three cycles after the start write.
    run_txn(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 6'h00, 3, 0);
    // Zero operand raises ZF only.
    run_txn(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 6'b000001, 2, 0);
    // Done still set from the previous op until the start write lands.
    run_txn(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 6'h00, 5, 0);
    // Backpressure, then an immediate back-to-back command.
    run_txn(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 6'b000010, 1, 5);
    run_txn(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 6'b000100, 2, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn($urandom, $urandom, $urandom, 6'($urandom_range(0, 63)),
              $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // Reset while polling abandons the operation.
    nx_never = 1;
    wr_q.delete();
    cmd_a = 32'h1234_5678; cmd_b = 32'h9ABC_DEF0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("poll_addr", {30'h0, A}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    check("mid_rst_WE", {31'h0, WE}, 32'h0);
    check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_writes", wr_q.size(), 0);
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6'h00, 2, 1);

    // Model that never finishes.
    nx_never = 1;
    wr_q.delete();
`ifdef FPMUL_DRV_TIMEOUT_EN
    issue(32'h4000_0000, 32'h4000_0000);
    wait_rsp(lat);
    // First POLL at cycle 5, sixteen POLL cycles, then RESP.
    check("to_latency", lat, 21);
    check("to_flag", {31'h0, rsp_timeout}, 32'h1);
    check("to_p", rsp_p, 32'h0);
    check("to_flags", {26'h0, rsp_flags}, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("to_idle", {31'h0, cmd_ready}, 32'h1);
    run_txn(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6'h00, 2, 0);
`else
    issue(32'h4000_0000, 32'h4000_0000);
    repeat (1000) @(negedge clk);
    check("hang_busy", {31'h0, busy}, 32'h1);
    check("hang_valid", {31'h0, rsp_valid}, 32'h0);
    check("hang_addr", {30'h0, A}, 32'h3);
    check("hang_timeout", {31'h0, rsp_timeout}, 32'h0);
    check("hang_writes", wr_q.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
